// File: rtl/fb_fill.sv
// fb_fill: rectangle / full-frame fill engine for a linear frame buffer.
// Emits one pixel write per accepted cycle in row-major order. Row addresses
// are tracked incrementally (row base + x), so the only multiply is the
// one-off y0*WIDTH load when a fill is latched.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start (or the pending post-reset auto-clear)
// FILL  | driving writes; advancing x/y only on accepted writes
// DONE  | one-cycle completion pulse, then back to IDLE
module fb_fill #(
  parameter int                WIDTH        = 160,
  parameter int                HEIGHT       = 120,
  parameter int                CW           = 12,
  parameter int                AW           = 15,
  parameter logic [CW-1:0]     CLEAR_COLOUR = 12'hFFF,
  parameter bit                AUTO_CLEAR   = 1'b1,
  localparam int               XW           = $clog2(WIDTH),
  localparam int               YW           = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour,
  input  logic          stall,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] wdata,
  output logic          busy,
  output logic          done
);

  localparam logic [XW-1:0] XMAX    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX    = YW'(HEIGHT - 1);
  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          pend_clear;
  logic [XW-1:0] x, lx0, lx1;
  logic [YW-1:0] y, ly1;
  logic [AW-1:0] rowbase;

  // start-time view of the request: auto-clear overrides the pins
  logic          go;
  logic [XW-1:0] sx0, sx1;
  logic [YW-1:0] sy0, sy1;
  logic [CW-1:0] scol;
  logic          sempty;
  logic [AW-1:0] srow;

  // Resolve mode, clamp upper bounds and detect an empty rectangle.
  always_comb begin
    go   = pend_clear | start;
    sx0  = '0;
    sx1  = XMAX;
    sy0  = '0;
    sy1  = YMAX;
    scol = CLEAR_COLOUR;
    if (!pend_clear && mode) begin
      sx0  = x0;
      sx1  = (x1 > XMAX) ? XMAX : x1;
      sy0  = y0;
      sy1  = (y1 > YMAX) ? YMAX : y1;
      scol = colour;
    end
    sempty = (sx0 > sx1) || (sy0 > sy1);
    srow   = AW'(sy0) * WIDTH_A;
  end

  // Fill sequencer with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_clear <= AUTO_CLEAR;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x          <= '0;
      y          <= '0;
      lx0        <= '0;
      lx1        <= '0;
      ly1        <= '0;
      rowbase    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            pend_clear <= 1'b0;
            lx0        <= sx0;
            lx1        <= sx1;
            ly1        <= sy1;
            x          <= sx0;
            y          <= sy0;
            rowbase    <= srow;
            wdata      <= scol;
            if (sempty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FILL;
              we    <= 1'b1;
              busy  <= 1'b1;
              addr  <= srow + AW'(sx0);
            end
          end
        end
        FILL: begin
          // a stalled write holds every output until the memory takes it
          if (!stall) begin
            if (x == lx1 && y == ly1) begin
              state <= DONE;
              we    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (x == lx1) begin
              x       <= lx0;
              y       <= y + 1'b1;
              rowbase <= rowbase + WIDTH_A;
              addr    <= rowbase + WIDTH_A + AW'(lx0);
            end else begin
              x    <= x + 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          we    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill.sv
// tb_fb_fill: scoreboard bench for fb_fill. Expected writes are pushed when a
// fill is requested and popped by a negedge monitor on each accepted write.
module tb_fb_fill;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int CW     = 12;
  localparam int AW     = 15;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  logic          clk;
  logic          reset;
  logic          start;
  logic          mode;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [CW-1:0] colour;
  logic          stall;
  logic          we;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata;
  logic          busy;
  logic          done;

  fb_fill dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .x0     (x0),
    .x1     (x1),
    .y0     (y0),
    .y1     (y1),
    .colour (colour),
    .stall  (stall),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [AW+CW-1:0] exp_q[$];
  logic [AW+CW-1:0] e_item;

  // reference model: plain nested loops with a full multiply per pixel
  function automatic int push_fill(bit m, logic [XW-1:0] a0, logic [XW-1:0] a1,
                                   logic [YW-1:0] b0, logic [YW-1:0] b1,
                                   logic [CW-1:0] c);
    int xs, xe, ys, ye, n;
    logic [CW-1:0] col;
    if (!m) begin
      xs = 0; xe = WIDTH - 1; ys = 0; ye = HEIGHT - 1; col = 12'hFFF;
    end else begin
      xs = int'(a0);
      xe = (int'(a1) > WIDTH - 1) ? WIDTH - 1 : int'(a1);
      ys = int'(b0);
      ye = (int'(b1) > HEIGHT - 1) ? HEIGHT - 1 : int'(b1);
      col = c;
    end
    n = 0;
    for (int yy = ys; yy <= ye; yy++)
      for (int xx = xs; xx <= xe; xx++) begin
        exp_q.push_back({AW'(yy * WIDTH + xx), col});
        n++;
      end
    return n;
  endfunction

  int               busy_cnt = 0;
  int               acc_cnt  = 0;
  int               done_cnt = 0;
  logic             prev_acc = 1'b0;
  logic             prev_hold = 1'b0;
  logic             done_after_acc = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [CW-1:0]    prev_wdata = '0;

  // monitor: pops the scoreboard on accepted writes, checks stall hold and done
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      check("busy_vs_we", 32'(busy), 32'(we));
      if (prev_hold) begin
        check("hold_we", 32'(we), 32'd1);
        check("hold_addr", 32'(addr), 32'(prev_addr));
        check("hold_wdata", 32'(wdata), 32'(prev_wdata));
      end
      if (done) begin
        done_cnt++;
        done_after_acc = prev_acc;
        check("q_empty_at_done", 32'(exp_q.size()), 32'd0);
        check("we_at_done", 32'(we), 32'd0);
      end
      if (we && !stall) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          e_item = exp_q.pop_front();
          check("addr", 32'(addr), 32'(e_item[AW+CW-1:CW]));
          check("wdata", 32'(wdata), 32'(e_item[CW-1:0]));
        end
      end
      prev_acc   = we && !stall;
      prev_hold  = we && stall;
      prev_addr  = addr;
      prev_wdata = wdata;
    end else begin
      prev_acc  = 1'b0;
      prev_hold = 1'b0;
    end
  end

  task automatic wait_done(string tag, int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Drive one request, scramble the pins during the fill, then check totals.
  task automatic run(string tag, bit m, logic [XW-1:0] a0, logic [XW-1:0] a1,
                     logic [YW-1:0] b0, logic [YW-1:0] b1, logic [CW-1:0] c,
                     int stall_cycles, int budget);
    int nexp, bs, ds, as;
    bs = busy_cnt; ds = done_cnt; as = acc_cnt;
    mode = m; x0 = a0; x1 = a1; y0 = b0; y1 = b1; colour = c; start = 1'b1;
    nexp = push_fill(m, a0, a1, b0, b1, c);
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    x0 = XW'($urandom); x1 = XW'($urandom);
    y0 = YW'($urandom); y1 = YW'($urandom);
    colour = CW'($urandom);
    wait_done(tag, budget);
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(busy_cnt - bs), 32'(nexp + stall_cycles));
    check({tag, "_done"}, 32'(done_cnt - ds), 32'd1);
    check({tag, "_writes"}, 32'(acc_cnt - as), 32'(nexp));
    if (nexp > 0) check({tag, "_done_after_last"}, 32'(done_after_acc), 32'd1);
  endtask

  initial begin
    int bs, ds, as, na, nb;
    bit hit;
    reset = 1'b1; start = 1'b0; mode = 1'b0; stall = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // auto-clear after reset release
    bs = busy_cnt; ds = done_cnt;
    na = push_fill(1'b0, '0, '0, '0, '0, '0);
    reset = 1'b0;
    wait_done("autoclr", 20000);
    @(posedge clk); #1;
    check("autoclr_busy", 32'(busy_cnt - bs), 32'(na));
    check("autoclr_done", 32'(done_cnt - ds), 32'd1);
    check("autoclr_done_after_last", 32'(done_after_acc), 32'd1);

    run("rect", 1'b1, 8'd10, 8'd12, 7'd5, 7'd6, 12'h0F0, 0, 50);

    // same rectangle with a 3-cycle stall on address 811
    hit = 1'b0;
    fork
      run("stall", 1'b1, 8'd10, 8'd12, 7'd5, 7'd6, 12'h0F0, 3, 50);
      begin
        repeat (20) begin
          @(posedge clk); #1;
          if (!hit && we && addr == AW'(811)) begin
            hit = 1'b1;
            stall = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            stall = 1'b0;
          end
        end
      end
    join
    check("stall_hit", 32'(hit), 32'd1);

    run("clamp_x", 1'b1, 8'd158, 8'd200, 7'd0, 7'd0, 12'h123, 0, 50);
    run("clamp_y", 1'b1, 8'd0, 8'd3, 7'd118, 7'd125, 12'hABC, 0, 50);
    run("empty", 1'b1, 8'd5, 8'd3, 7'd0, 7'd0, 12'h555, 0, 2);

    // start held high with a different rectangle presented during the fill
    bs = busy_cnt; ds = done_cnt; as = acc_cnt;
    mode = 1'b1; x0 = 8'd20; x1 = 8'd22; y0 = 7'd1; y1 = 7'd1; colour = 12'h00F;
    start = 1'b1;
    na = push_fill(1'b1, 8'd20, 8'd22, 7'd1, 7'd1, 12'h00F);
    @(posedge clk); #1;
    x0 = 8'd30; x1 = 8'd31; y0 = 7'd2; y1 = 7'd2; colour = 12'hF00;
    wait_done("held_a", 50);
    @(posedge clk); #1;
    check("held_one_done", 32'(done_cnt - ds), 32'd1);
    check("held_a_writes", 32'(acc_cnt - as), 32'(na));
    nb = push_fill(1'b1, 8'd30, 8'd31, 7'd2, 7'd2, 12'hF00);
    wait_done("held_b", 50);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_two_done", 32'(done_cnt - ds), 32'd2);
    check("held_writes", 32'(acc_cnt - as), 32'(na + nb));
    check("held_busy", 32'(busy_cnt - bs), 32'(na + nb));

    // reset in the middle of an auto-clear
    ds = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    void'(push_fill(1'b0, '0, '0, '0, '0, '0));
    as = acc_cnt;
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (acc_cnt - as >= 100) break;
    end
    check("rst_at_100", 32'(acc_cnt - as), 32'd100);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_we", 32'(we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    na = push_fill(1'b0, '0, '0, '0, '0, '0);
    as = acc_cnt;
    wait_done("rerun", 20000);
    @(posedge clk); #1;
    check("rerun_done", 32'(done_cnt - ds), 32'd1);
    check("rerun_writes", 32'(acc_cnt - as), 32'(na));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_fill.md
FB_FILL -- requirements
Module: fb_fill

Interface
REQ-001 Parameter WIDTH, default 160, frame width in pixels.
REQ-002 Parameter HEIGHT, default 120, frame height in pixels.
REQ-003 Parameter CW, default 12, colour width in bits.
REQ-004 Parameter AW, default 15, address width; WIDTH*HEIGHT SHALL be at most 2**AW.
REQ-005 Parameter CLEAR_COLOUR, default 12'hFFF (CW bits), colour used for full-frame clears.
REQ-006 Parameter AUTO_CLEAR, default 1, run a full clear automatically after reset release.
REQ-007 Derived: XW = clog2(WIDTH), YW = clog2(HEIGHT).
REQ-008 clk  in  1  clock; all logic on rising edge.
REQ-009 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-010 start  in  1  request a fill; sampled only in IDLE.
REQ-011 mode  in  1  0 = full clear with CLEAR_COLOUR, 1 = rectangle fill with colour.
REQ-012 x0, x1  in  XW  inclusive rectangle column bounds.
REQ-013 y0, y1  in  YW  inclusive rectangle row bounds.
REQ-014 colour  in  CW  rectangle fill colour.
REQ-015 stall  in  1  memory not ready; the current write is not accepted.
REQ-016 we  out  1  write enable to the frame buffer.
REQ-017 addr  out  AW  write address, y*WIDTH + x.
REQ-018 wdata  out  CW  write data.
REQ-019 busy  out  1  engine is filling.
REQ-020 done  out  1  one-cycle pulse at fill completion.

Function
REQ-021 The FSM SHALL have states IDLE, FILL and DONE.
REQ-022 In IDLE, start=1 SHALL latch mode, bounds and colour; the FSM SHALL enter FILL, and we SHALL be asserted in the next cycle.
REQ-023 Mode 0 SHALL use bounds (0,0)-(WIDTH-1,HEIGHT-1) and CLEAR_COLOUR.
REQ-024 Latched x1 above WIDTH-1 SHALL clamp to WIDTH-1, and y1 above HEIGHT-1 SHALL clamp to HEIGHT-1, before use.
REQ-025 If x0>x1 or y0>y1 after clamping, the FSM SHALL go IDLE->DONE with zero writes.
REQ-026 Scan order SHALL be row-major: x from x0 to x1, then y+1 and x back to x0; we=1 in every FILL cycle.
REQ-027 addr SHALL be computed incrementally: a row-base register is loaded with y0*WIDTH and advanced by WIDTH per row, and addr = rowbase + x; no multiplier on the per-pixel path.
REQ-028 A write SHALL be accepted when we=1 and stall=0; only accepted writes advance x/y.
REQ-029 While stall=1, we, addr and wdata SHALL hold their values, and no pixel SHALL be skipped or repeated as accepted.
REQ-030 After the write to (x1,y1) is accepted, the next cycle SHALL have we=0 with the FSM in DONE; done=1 for exactly that cycle, then the FSM returns to IDLE.
REQ-031 busy SHALL be 1 exactly in FILL cycles.
REQ-032 start SHALL be ignored in FILL and DONE, and input changes during FILL SHALL have no effect.
REQ-033 With AUTO_CLEAR=1, the first cycle after reset deasserts SHALL behave as start=1 with mode=0.

Reset
REQ-034 With reset=1, at the next edge: FSM=IDLE, we=0, addr=0, wdata=0, busy=0, done=0, counters=0.
REQ-035 Reset asserted mid-fill SHALL abort the fill at the next edge with no done pulse; the auto-clear SHALL rerun afterwards if AUTO_CLEAR=1.

Verification
REQ-036 Defaults; release reset -> 19200 writes, addr 0..19199 consecutive, wdata 0xFFF, done one cycle after addr 19199.
REQ-037 mode=1, x0=10, y0=5, x1=12, y1=6, colour=0x0F0 -> addr 810,811,812,970,971,972, then done; 6 busy cycles.
REQ-038 Same rectangle, stall=1 for 3 cycles while addr=811 -> addr 811 with we=1 held 4 cycles; sequence otherwise unchanged; 9 busy cycles.
REQ-039 x0=158, x1=200 (XW permits), y0=y1=0 -> writes 158,159 only; x0=5, x1=3 -> no writes, done next cycle.
REQ-040 reset pulsed at write 100 of a clear -> we=0 next cycle, no done, then auto-clear restarts at addr 0.
REQ-041 start held high throughout a fill with a different rectangle -> ignored until IDLE; exactly one done per accepted start.
